// File: rtl/mix_columns_iter.sv
// -----------------------------------------------------------------------------
// mix_columns_iter
//
// Sequential AES MixColumns / InvMixColumns for the vector AES path. One
// 128-bit state is accepted per transaction. COLS_PER_CYCLE columns are
// transformed per clock into an output register. The result is held there
// until the downstream stage takes it.
//
// Column c of a state is bits [127-32c -: 32]. The top byte of a column is
// row 0.
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. The source holds its payload stable while valid is high and not
// yet accepted. The sink may change ready at any time.
//
// Parameters
//   COLS_PER_CYCLE  columns transformed per clock (1, 2 or 4)
//   INV_EN          1: inverse_sel honoured; 0: forward transform only
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   in_valid     state_in / inverse_sel valid
//   in_ready     block can accept a new state (IDLE)
//   state_in     input state matrix
//   inverse_sel  0 = MixColumns, 1 = InvMixColumns, sampled on accept
//   out_valid    state_out holds a completed result (DONE)
//   out_ready    downstream accepts the result
//   state_out    transformed state, same layout as state_in
//   busy         high in BUSY or DONE
// -----------------------------------------------------------------------------
module mix_columns_iter #(
  parameter int COLS_PER_CYCLE = 1,
  parameter bit INV_EN         = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] state_in,
  input  logic         inverse_sel,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] state_out,
  output logic         busy
);

  if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cpc
    $error("mix_columns_iter: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  localparam int         GROUPS   = 4 / COLS_PER_CYCLE;
  localparam logic [1:0] LAST_GRP = 2'(GROUPS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t       state;
  state_t       state_next;
  logic [1:0]   col_cnt;
  logic [127:0] work_q;
  logic [127:0] out_q;
  logic [127:0] out_next;
  logic         inv_q;
  logic         rdy_q;
  logic         vld_q;
  logic         accept;
  logic         release_out;

  // ---------------------------------------------------------------------------
  // GF(2^8) helpers, polynomial 0x11B. Only xtime chains are used.
  // ---------------------------------------------------------------------------
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Transform one 32-bit column. The inverse branch is guarded by the INV_EN
  // constant, so it disappears entirely when INV_EN = 0.
  function automatic logic [31:0] mix_col(input logic [31:0] c, input logic inv);
    logic [7:0] s  [4];
    logic [7:0] x2 [4];
    logic [7:0] x4 [4];
    logic [7:0] x8 [4];
    logic [7:0] r  [4];
    for (int k = 0; k < 4; k++) begin
      s[k]  = c[31-8*k -: 8];
      x2[k] = xtime(s[k]);
      x4[k] = xtime(x2[k]);
      x8[k] = xtime(x4[k]);
    end
    for (int i = 0; i < 4; i++) begin
      if (INV_EN && inv) begin
        // 0E*s_i ^ 0B*s_i+1 ^ 0D*s_i+2 ^ 09*s_i+3
        r[i] = (x8[i] ^ x4[i] ^ x2[i])
             ^ (x8[(i+1)%4] ^ x2[(i+1)%4] ^ s[(i+1)%4])
             ^ (x8[(i+2)%4] ^ x4[(i+2)%4] ^ s[(i+2)%4])
             ^ (x8[(i+3)%4] ^ s[(i+3)%4]);
      end else begin
        // 02*s_i ^ 03*s_i+1 ^ s_i+2 ^ s_i+3
        r[i] = x2[i] ^ x2[(i+1)%4] ^ s[(i+1)%4] ^ s[(i+2)%4] ^ s[(i+3)%4];
      end
    end
    return {r[0], r[1], r[2], r[3]};
  endfunction

  // ---------------------------------------------------------------------------
  // Handshake qualifiers
  // ---------------------------------------------------------------------------
  assign accept      = in_valid && rdy_q;
  assign release_out = vld_q && out_ready;

  // ---------------------------------------------------------------------------
  // FSM next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (accept)             state_next = BUSY;
      BUSY: if (col_cnt == LAST_GRP) state_next = DONE;
      DONE: if (release_out)        state_next = IDLE;
      default:                      state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Column datapath: the current group of columns is written into the output
  // register; other columns keep their previous (possibly stale) contents.
  // ---------------------------------------------------------------------------
  always_comb begin
    out_next = out_q;
    if (state == BUSY) begin
      for (int g = 0; g < COLS_PER_CYCLE; g++) begin
        out_next[127 - 32*(int'(col_cnt)*COLS_PER_CYCLE + g) -: 32] =
          mix_col(work_q[127 - 32*(int'(col_cnt)*COLS_PER_CYCLE + g) -: 32], inv_q);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State and data registers. in_ready / out_valid are registered copies of
  // "next state is IDLE / DONE". This holds in_ready low during reset and
  // raises it on the first edge after release.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      col_cnt <= 2'd0;
      work_q  <= '0;
      out_q   <= '0;
      inv_q   <= 1'b0;
      rdy_q   <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      state <= state_next;
      rdy_q <= (state_next == IDLE);
      vld_q <= (state_next == DONE);
      if (accept) begin
        work_q  <= state_in;
        inv_q   <= inverse_sel & INV_EN;
        col_cnt <= 2'd0;
      end else if (state == BUSY) begin
        out_q   <= out_next;
        col_cnt <= (col_cnt == LAST_GRP) ? 2'd0 : col_cnt + 2'd1;
      end
    end
  end

  assign in_ready  = rdy_q;
  assign out_valid = vld_q;
  assign state_out = out_q;
  assign busy      = (state != IDLE);

endmodule

// File: doc/mix_columns_iter.md
Name: mix_columns_iter

Overview:
- Sequential, parametrised successor to the combinational AES MixColumns stage in the execute stage of the SIMD processor.
- Accepts one 128-bit state per transaction through a valid/ready handshake and processes COLS_PER_CYCLE columns per clock. It supports forward (encrypt) and inverse (decrypt) MixColumns, selectable per transaction.
- The result is held in an output register until the downstream stage accepts it. This trades area against latency for the vector AES path.

Parameters:
- COLS_PER_CYCLE, 1, number of 32-bit columns transformed per clock. Legal values are 1, 2 and 4; any other value is an elaboration error.
- INV_EN, 1, when 1 `inverse_sel` is honoured. When 0 the inverse datapath is not built and `inverse_sel` is ignored (forward only).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  `state_in` and `inverse_sel` are valid.
- in_ready  output  1  block can accept a new state.
- state_in  input  128  input state matrix; column c = `state_in[127-32c -: 32]`, and the top byte of each column is row 0.
- inverse_sel  input  1  0 = MixColumns, 1 = InvMixColumns; sampled only on accept.
- out_valid  output  1  `state_out` holds a completed result.
- out_ready  input  1  downstream accepts the result.
- state_out  output  128  transformed state, same column/byte layout as `state_in`.
- busy  output  1  high in BUSY or DONE.

Behaviour:
- Reset (asynchronous, while rst_n=0):
  - state=IDLE, col_cnt=0.
  - Input and output registers cleared to 0; `state_out`=0.
  - out_valid=0, busy=0, in_ready=0 while rst_n=0.
  - in_ready=1 from the first edge after deassertion (IDLE).
- Arithmetic:
  - For each column s0..s3, out_r = XOR over k of gf_mul(M[r][k], s_k), in GF(2^8) with polynomial 0x11B.
  - Forward M is the circulant with first row {02,03,01,01}.
  - Inverse M is the circulant with first row {0E,0B,0D,09}.
  - Multiplication by constants uses xtime chains only; no general multiplier.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: in_ready=1.
    - Accept when in_valid&&in_ready: latch `state_in` into the work register.
    - Latch the mode as inv_q = inverse_sel&&INV_EN.
    - col_cnt=0, then go to BUSY.
  - BUSY: in_ready=0.
    - Each edge transforms columns col_cnt*CPC .. col_cnt*CPC+CPC-1 into the output register, then col_cnt++.
    - On the edge handling the last group (col_cnt = 4/CPC-1), col_cnt wraps to 0, the state goes to DONE and out_valid=1.
  - DONE: out_valid=1; `state_out` is stable and unchanged until the handshake.
    - On out_valid&&out_ready, go to IDLE and set out_valid=0 on that edge.
    - No new input is accepted in the same cycle (in_ready=0 in DONE).
- Latency and throughput:
  - out_valid rises 4/CPC edges after the accept edge: 4, 2 or 1 for CPC=1, 2 or 4.
  - Minimum initiation interval is 4/CPC+2 cycles with out_ready held high.
- Input side:
  - Changes to `state_in` or `inverse_sel` after accept have no effect on the transaction in flight.
  - in_valid while not in IDLE is ignored; the upstream stage must hold it.
- Output side:
  - Columns not yet processed in BUSY may hold stale data in the output register.
  - This is not observable, because `state_out` is only defined while out_valid=1.
- Back-pressure: out_ready=0 keeps DONE indefinitely; `state_out` and out_valid are held.
- Mid-operation reset: a reset asserted in BUSY or DONE aborts the transaction immediately. No partial result is ever presented.
- INV_EN=0: inverse_sel=1 produces the forward transform.

Test Plan:
- FIPS-197 column, forward, CPC=4: column db135345 in all four columns, inverse_sel=0 -> `state_out` = 8e4da1bc repeated, out_valid exactly 1 edge after accept.
- Inverse round-trip, CPC=1: `state_in`=8e4da1bc_9fdc589d_0466 81e5_8e4da1bc, inverse_sel=1 -> db135345_f20a225c_d4bf5d30_db135345.
  - out_valid exactly 4 edges after accept.
  - in_ready=0 from the accept edge until DONE->IDLE.
- Per-column mapping, CPC=2: `state_in`=d4bf5d30_f20a225c_db135345_01010101, forward -> 046681e5_9fdc589d_8e4da1bc_01010101.
  - out_valid 2 edges after accept.
  - `state_in` is changed to random data in the cycle after accept and the result is unchanged.
- Back-pressure: hold out_ready=0 for 10 cycles after out_valid -> `state_out` stable, in_ready=0 throughout.
  - out_ready=1 -> out_valid=0 on the next edge, in_ready=1.
  - A back-to-back second transaction with inverse_sel=1 returns the correct inverse result.
- Reset mid-operation, CPC=1: assert rst_n=0 asynchronously two cycles after accept -> out_valid=0 and `state_out`=0 immediately, no result emitted.
  - After release, a new transaction completes correctly.
- INV_EN=0: inverse_sel=1 with column db135345 -> 8e4da1bc (forward result).
